// File: rtl/shift_pkg.sv
// Shared definitions for the shift normalizer.
// Holds the FSM state encoding, the per-stage shift amounts and the
// SHAMT value that is reported for an all-zero operand.
package shift_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  // One state per shift stage, bracketed by IDLE and the result-publish state
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S16  = 3'd1,
    S8   = 3'd2,
    S4   = 3'd3,
    S2   = 3'd4,
    S1   = 3'd5,
    FIN  = 3'd6
  } state_t;

  localparam logic [4:0] K16 = 5'd16;
  localparam logic [4:0] K8  = 5'd8;
  localparam logic [4:0] K4  = 5'd4;
  localparam logic [4:0] K2  = 5'd2;
  localparam logic [4:0] K1  = 5'd1;
  localparam logic [4:0] K0  = 5'd0;

  localparam logic [CNT_W-1:0] SHAMT_ZERO = 6'd32;
  localparam logic [WIDTH-1:0] ALL_ONES   = 32'hFFFF_FFFF;

endpackage

// File: rtl/norm_stage.sv
// Combinational normalization test for one stage of amount k.
// Unsigned: passes when the top k bits are zero.
// Signed (only with SHIFT_NORMALIZER_SIGNED_EN): passes when the top k+1
// bits are all equal, i.e. the top k bits are redundant sign copies.
// The shifted output is the work value moved left by k, zero-filled.
module norm_stage
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] work,
  input  logic [4:0]       k,
  input  logic             signed_mode,
  output logic             pass,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] top_k_s;
`ifdef SHIFT_NORMALIZER_SIGNED_EN
  logic [WIDTH-1:0] top_k1_s;
`else
  logic             unused_mode_s;
  assign unused_mode_s = signed_mode;
`endif

  // Mask the leading bits under test and decide pass/fail plus shifted value
  always_comb begin
    top_k_s = ~(ALL_ONES >> k);
    shifted = work << k;
`ifdef SHIFT_NORMALIZER_SIGNED_EN
    top_k1_s = ~(ALL_ONES >> ({1'b0, k} + 6'd1));
    if (signed_mode) begin
      pass = ((work & top_k1_s) == 32'd0) || ((work & top_k1_s) == top_k1_s);
    end else begin
      pass = ((work & top_k_s) == 32'd0);
    end
`else
    pass = ((work & top_k_s) == 32'd0);
`endif
  end

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle 32-bit normalizer: left-shifts an operand until normalized
// and reports the shift count, using a 16/8/4/2/1 binary search, one stage
// per clock. Fixed latency: DONE is high in the cycle after the sixth edge
// following the accepted START.
// Optional feature: define SHIFT_NORMALIZER_SIGNED_EN to honor SIGNED_MODE
// (redundant sign-bit removal); otherwise every operation is unsigned.
module shift_normalizer
  import shift_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED_MODE,
  input  logic [WIDTH-1:0] DIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DOUT,
  output logic [CNT_W-1:0] SHAMT,
  output logic             ZERO
);

  state_t           state_r;
  state_t           state_s;
  logic [4:0]       k_s;
  logic [WIDTH-1:0] work_r;
  logic [CNT_W-1:0] cnt_r;
  logic             op_zero_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] dout_r;
  logic [CNT_W-1:0] shamt_r;
  logic             zero_r;
  logic             pass_s;
  logic [WIDTH-1:0] shifted_s;
  logic             mode_s;

`ifdef SHIFT_NORMALIZER_SIGNED_EN
  logic             mode_r;

  // Capture the normalization mode together with the operand
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_r <= 1'b0;
    end else if ((state_r == IDLE) && START) begin
      mode_r <= SIGNED_MODE;
    end
  end

  assign mode_s = mode_r;
`else
  logic unused_signed_mode_s;
  assign unused_signed_mode_s = SIGNED_MODE;
  assign mode_s = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state sequencing and per-state stage amount
  always_comb begin
    state_s = state_r;
    k_s     = K0;
    case (state_r)
      IDLE: begin
        if (START) begin
          state_s = S16;
        end else begin
          state_s = IDLE;
        end
      end
      S16: begin
        k_s     = K16;
        state_s = S8;
      end
      S8: begin
        k_s     = K8;
        state_s = S4;
      end
      S4: begin
        k_s     = K4;
        state_s = S2;
      end
      S2: begin
        k_s     = K2;
        state_s = S1;
      end
      S1: begin
        k_s     = K1;
        state_s = FIN;
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  norm_stage u_stage (
    .work        (work_r),
    .k           (k_s),
    .signed_mode (mode_s),
    .pass        (pass_s),
    .shifted     (shifted_s)
  );

  // Work register, shift count and registered results
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      work_r    <= 32'd0;
      cnt_r     <= 6'd0;
      op_zero_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dout_r    <= 32'd0;
      shamt_r   <= 6'd0;
      zero_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (START) begin
            work_r    <= DIN;
            cnt_r     <= 6'd0;
            op_zero_r <= (DIN == 32'd0);
            busy_r    <= 1'b1;
          end
        end
        S16, S8, S4, S2, S1: begin
          if (pass_s) begin
            work_r <= shifted_s;
            cnt_r  <= cnt_r + {1'b0, k_s};
          end
        end
        FIN: begin
          dout_r <= work_r;
          // A zero operand passes every stage (count 31); report 32 instead
          if (op_zero_r) begin
            shamt_r <= SHAMT_ZERO;
            zero_r  <= 1'b1;
          end else begin
            shamt_r <= cnt_r;
            zero_r  <= 1'b0;
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY  = busy_r;
  assign DONE  = done_r;
  assign DOUT  = dout_r;
  assign SHAMT = shamt_r;
  assign ZERO  = zero_r;

endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer: stimulus pushes hand-computed
// expectations (including the edge on which DONE must appear); a monitor
// pops and compares on every DONE. Signed vectors carry expectations for
// both builds, selected by SHIFT_NORMALIZER_SIGNED_EN.
module tb_shift_normalizer;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        SIGNED_MODE;
  logic [31:0] DIN;
  logic        BUSY;
  logic        DONE;
  logic [31:0] DOUT;
  logic [5:0]  SHAMT;
  logic        ZERO;

  typedef struct {
    logic [31:0] dout;
    logic [5:0]  shamt;
    logic        zero;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  shift_normalizer dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .SIGNED_MODE (SIGNED_MODE),
    .DIN         (DIN),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .DOUT        (DOUT),
    .SHAMT       (SHAMT),
    .ZERO        (ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count rising edges so expectations can name the edge DONE must follow
  always @(posedge CLK) edge_cnt = edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every DONE must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (DONE === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("dout",    DOUT,                 e.dout);
        check("shamt",   {26'd0, SHAMT},       {26'd0, e.shamt});
        check("zero",    {31'd0, ZERO},        {31'd0, e.zero});
        check("latency", edge_cnt,             e.due);
      end
    end
  end

  // Present one operand for a single accepted edge; optionally record expectation
  task automatic issue(input logic [31:0] d, input logic m, input bit push,
                       input logic [31:0] xd, input logic [5:0] xs, input logic xz);
    exp_t e;
    @(negedge CLK);
    START       = 1'b1;
    SIGNED_MODE = m;
    DIN         = d;
    @(posedge CLK);
    #1;
    START = 1'b0;
    if (push) begin
      e.dout  = xd;
      e.shamt = xs;
      e.zero  = xz;
      e.due   = edge_cnt + 6;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_op(input logic [31:0] d, input logic m,
                        input logic [31:0] xd, input logic [5:0] xs, input logic xz);
    issue(d, m, 1'b1, xd, xs, xz);
    repeat (7) @(negedge CLK);
  endtask

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   busy_cycles;
    exp_t e;
    RST         = 1'b1;
    START       = 1'b0;
    SIGNED_MODE = 1'b0;
    DIN         = 32'd0;
    repeat (3) @(negedge CLK);
    check("rst_busy",  {31'd0, BUSY},  32'd0);
    check("rst_done",  {31'd0, DONE},  32'd0);
    check("rst_dout",  DOUT,           32'd0);
    check("rst_shamt", {26'd0, SHAMT}, 32'd0);
    check("rst_zero",  {31'd0, ZERO},  32'd0);
    RST = 1'b0;

    // Unsigned 1, also observe BUSY width
    issue(32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 6'd31, 1'b0);
    busy_cycles = 0;
    repeat (6) begin
      @(negedge CLK);
      if (BUSY === 1'b1) busy_cycles = busy_cycles + 1;
    end
    check("busy_cycles", busy_cycles, 32'd6);
    @(negedge CLK);
    check("busy_done_cycle", {31'd0, BUSY}, 32'd0);

    run_op(32'h00F0_0000, 1'b0, 32'hF000_0000, 6'd8,  1'b0);
    run_op(32'h8000_0000, 1'b0, 32'h8000_0000, 6'd0,  1'b0);
    run_op(32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1);
    run_op(32'h0000_0000, 1'b1, 32'h0000_0000, 6'd32, 1'b1);
`ifdef SHIFT_NORMALIZER_SIGNED_EN
    run_op(32'hFFFF_FF00, 1'b1, 32'h8000_0000, 6'd23, 1'b0);
    run_op(32'h0000_0003, 1'b1, 32'h6000_0000, 6'd29, 1'b0);
    run_op(32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 6'd31, 1'b0);
    run_op(32'h4000_0000, 1'b1, 32'h4000_0000, 6'd0,  1'b0);
`else
    run_op(32'hFFFF_FF00, 1'b1, 32'hFFFF_FF00, 6'd0,  1'b0);
    run_op(32'h0000_0003, 1'b1, 32'hC000_0000, 6'd30, 1'b0);
    run_op(32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 6'd0,  1'b0);
    run_op(32'h4000_0000, 1'b1, 32'h8000_0000, 6'd1,  1'b0);
`endif
    run_op(32'h0000_0003, 1'b0, 32'hC000_0000, 6'd30, 1'b0);

    // Reset while the S4 stage is active: no DONE, outputs cleared
    issue(32'h0000_0001, 1'b0, 1'b0, 32'd0, 6'd0, 1'b0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("abort_busy",  {31'd0, BUSY},  32'd0);
    check("abort_done",  {31'd0, DONE},  32'd0);
    check("abort_dout",  DOUT,           32'd0);
    check("abort_shamt", {26'd0, SHAMT}, 32'd0);
    repeat (8) @(negedge CLK);
    RST = 1'b0;
    run_op(32'h00F0_0000, 1'b0, 32'hF000_0000, 6'd8, 1'b0);

    // START held every cycle: operand change during BUSY is ignored,
    // START in the DONE cycle is accepted on the following edge
    @(negedge CLK);
    START       = 1'b1;
    SIGNED_MODE = 1'b0;
    DIN         = 32'h0000_0001;
    @(posedge CLK);
    #1;
    e.dout = 32'h8000_0000; e.shamt = 6'd31; e.zero = 1'b0; e.due = edge_cnt + 6;
    exp_q.push_back(e);
    e.dout = 32'h8000_0000; e.shamt = 6'd23; e.zero = 1'b0; e.due = edge_cnt + 13;
    exp_q.push_back(e);
    DIN = 32'h0000_0100;
    repeat (7) @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (10) @(negedge CLK);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
